// File: rtl/fetch_align_queue.sv
// ---------------------------------------------------------------------------
// fetch_align_queue
//
// Halfword prefetch queue and instruction aligner sitting between the
// instruction memory and the compressed decoder. Memory beats of FETCH_HW
// halfwords are buffered in a small shift queue. The head is presented as one
// instruction per handshake: 16-bit when hw0[1:0] != 2'b11, otherwise 32-bit.
// A 32-bit instruction whose halves arrive in different beats is presented
// once both halves are queued.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   Redirect          flush the queue and restart fetching at RedirectPC
//   RedirectPC        new PC (bit 0 ignored)
//   MemReq/MemAddr    beat-aligned fetch request, held until MemGnt
//   MemGnt            request accepted this cycle
//   MemRValid/MemRData in-order read response, halfword 0 at lowest address
//   InstValid/InstReady instruction handshake towards the decoder
//   InstData          {16'h0,hw0} when compressed, else {hw1,hw0}
//   InstCompressed    InstData holds a 16-bit instruction
//   InstPC            address of InstData
//   InstIllegal       head halfword is the defined-illegal 16'h0000
//
// Configuration
//   ALIGN_ILLEGAL_CHECK_EN  when defined, InstIllegal flags a 16'h0000 head
//                           (still presented and popped as compressed);
//                           when undefined, InstIllegal is tied to 0.
// ---------------------------------------------------------------------------
module fetch_align_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                FETCH_HW = 2,   // 1 or 2
  parameter int                QUEUE_HW = 6,   // >= 2*FETCH_HW+2
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Redirect,
  input  logic [ADDR_W-1:0]     RedirectPC,
  output logic                  MemReq,
  output logic [ADDR_W-1:0]     MemAddr,
  input  logic                  MemGnt,
  input  logic                  MemRValid,
  input  logic [16*FETCH_HW-1:0] MemRData,
  output logic                  InstValid,
  input  logic                  InstReady,
  output logic [31:0]           InstData,
  output logic                  InstCompressed,
  output logic [ADDR_W-1:0]     InstPC,
  output logic                  InstIllegal
);

  localparam int QW         = 16 * QUEUE_HW;
  localparam int BW         = 16 * FETCH_HW;
  localparam int CNT_W      = $clog2(QUEUE_HW + 1);
  localparam int BEAT_BYTES = 2 * FETCH_HW;

  localparam logic [ADDR_W-1:0] BEAT_MASK  = ADDR_W'(BEAT_BYTES - 1);
  localparam logic [CNT_W-1:0]  FETCH_CNT  = CNT_W'(FETCH_HW);
  // Highest post-update occupancy that still leaves room for a whole beat.
  localparam logic [CNT_W-1:0]  ISSUE_MAX  = CNT_W'(QUEUE_HW - FETCH_HW);
  // Only a two-halfword beat can start on its upper halfword.
  localparam bit                ALIGN_DROP = (FETCH_HW == 2);

  // Queue state: halfword i of the queue lives in qData[16*i +: 16]; the
  // head is always at index 0 so the output decode needs no pointer mux.
  logic [QW-1:0]     qData;
  logic [CNT_W-1:0]  qCount;

  logic [ADDR_W-1:0] fetchPtr;     // next beat address to request
  logic [ADDR_W-1:0] pcReg;        // address of the queue head
  logic [ADDR_W-1:0] memAddrReg;
  logic              memReqReg;
  logic              outstanding;  // granted beat awaiting its response
  logic              discard;      // the in-flight beat belongs to a stale PC
  logic              dropFirst;    // next accepted beat starts on hw1

  // Head decode
  logic [15:0]       hw0;
  logic [15:0]       hw1;
  logic              headCompressed;
  logic              instValid;
  logic              transfer;

  // Queue update
  logic              rspAccept;
  logic [CNT_W-1:0]  popCnt;
  logic [CNT_W-1:0]  pushCnt;
  logic [CNT_W-1:0]  baseCnt;
  logic [CNT_W-1:0]  countNext;
  logic [BW-1:0]     pushData;
  logic [QW-1:0]     shifted;
  logic [QW-1:0]     keepMask;
  logic [QW-1:0]     pushExt;
  logic [QW-1:0]     qNext;

  // Request control
  logic              stalePending;
  logic              canIssue;

  assign hw0            = qData[15:0];
  assign hw1            = qData[31:16];
  assign headCompressed = (hw0[1:0] != 2'b11);
  assign instValid      = ((qCount >= CNT_W'(1)) && headCompressed) ||
                          (qCount >= CNT_W'(2));
  // A redirect wins over a same-cycle handshake: nothing is consumed.
  assign transfer       = instValid && InstReady && !Redirect;
  // Responses are only trusted for a live, non-stale beat; this also ignores
  // a response that straggles in after reset.
  assign rspAccept      = MemRValid && outstanding && !discard && !Redirect;

  // Something from before a redirect is still in flight on the memory side.
  assign stalePending   = memReqReg || (outstanding && !MemRValid);

  // NOTE: every always_comb output gets a default before any condition so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    popCnt   = '0;
    pushCnt  = '0;
    pushData = MemRData;
    if (transfer) begin
      popCnt = headCompressed ? CNT_W'(1) : CNT_W'(2);
    end
    if (rspAccept) begin
      pushCnt = dropFirst ? CNT_W'(1) : FETCH_CNT;
    end
    if (dropFirst) begin
      pushData = MemRData >> 16;
    end

    baseCnt   = qCount - popCnt;
    countNext = baseCnt + pushCnt;

    // Pop by shifting toward the head, then lay the pushed halfwords in
    // directly behind the survivors; slots above the occupancy stay zero.
    shifted  = qData >> (16 * popCnt);
    keepMask = ~({QW{1'b1}} << (16 * baseCnt));
    pushExt  = QW'(pushData) << (16 * baseCnt);
    qNext    = (shifted & keepMask) | (rspAccept ? pushExt : '0);

    // A new beat is requested only when nothing is in flight and the queue,
    // after this cycle's push and pop, still has room for all of it.
    canIssue = !(outstanding && !MemRValid) &&
               !(discard && outstanding && MemRValid ? 1'b0 : discard) &&
               (countNext <= ISSUE_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the queue storage is a handful of flops, so it is cleared with
      // the control state; nothing reads it before the occupancy says so.
      qData       <= '0;
      qCount      <= '0;
      fetchPtr    <= RESET_PC & ~BEAT_MASK;
      pcReg       <= RESET_PC;
      memAddrReg  <= RESET_PC & ~BEAT_MASK;
      memReqReg   <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      dropFirst   <= ALIGN_DROP && RESET_PC[1];
    end else begin
      // At most one beat in flight: a grant opens it, a response closes it.
      if (memReqReg && MemGnt) begin
        outstanding <= 1'b1;
      end else if (MemRValid) begin
        outstanding <= 1'b0;
      end

      if (Redirect) begin
        qData     <= '0;
        qCount    <= '0;
        pcReg     <= {RedirectPC[ADDR_W-1:1], 1'b0};
        fetchPtr  <= RedirectPC & ~BEAT_MASK;
        dropFirst <= ALIGN_DROP && RedirectPC[1];
        discard   <= stalePending;
        if (memReqReg) begin
          // An ungranted request must stay stable; its data is dropped later.
          memReqReg <= !MemGnt;
        end else if (!stalePending) begin
          memReqReg  <= 1'b1;
          memAddrReg <= RedirectPC & ~BEAT_MASK;
        end
      end else begin
        qData  <= qNext;
        qCount <= countNext;
        if (transfer) begin
          pcReg <= pcReg + (headCompressed ? ADDR_W'(2) : ADDR_W'(4));
        end
        if (rspAccept) begin
          dropFirst <= 1'b0;
        end
        if (discard && outstanding && MemRValid) begin
          discard <= 1'b0;
        end
        // A stale grant must not advance the pointer of the new stream.
        if (memReqReg && MemGnt && !discard) begin
          fetchPtr <= fetchPtr + ADDR_W'(BEAT_BYTES);
        end
        if (memReqReg) begin
          memReqReg <= !MemGnt;
        end else if (canIssue) begin
          memReqReg  <= 1'b1;
          memAddrReg <= fetchPtr;
        end
      end
    end
  end

  assign MemReq         = memReqReg;
  assign MemAddr        = memAddrReg;
  assign InstValid      = instValid;
  assign InstData       = headCompressed ? {16'h0000, hw0} : {hw1, hw0};
  assign InstCompressed = headCompressed;
  assign InstPC         = pcReg;

`ifdef ALIGN_ILLEGAL_CHECK_EN
  // 16'h0000 has low bits 2'b00, so it is already handled as compressed.
  assign InstIllegal = instValid && (hw0 == 16'h0000);
`else
  assign InstIllegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_align_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_align_queue
//
// Directed bench for fetch_align_queue with default parameters (FETCH_HW=2,
// QUEUE_HW=6, RESET_PC=0). A small memory responder grants requests and
// returns words from a sparse image after a programmable latency.
// ---------------------------------------------------------------------------
module tb_fetch_align_queue;

  logic        clk;
  logic        rst_n;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemGnt;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] InstData;
  logic        InstCompressed;
  logic [31:0] InstPC;
  logic        InstIllegal;

  int checks = 0;
  int errors = 0;

`ifdef ALIGN_ILLEGAL_CHECK_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  fetch_align_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .MemReq         (MemReq),
    .MemAddr        (MemAddr),
    .MemGnt         (MemGnt),
    .MemRValid      (MemRValid),
    .MemRData       (MemRData),
    .InstValid      (InstValid),
    .InstReady      (InstReady),
    .InstData       (InstData),
    .InstCompressed (InstCompressed),
    .InstPC         (InstPC),
    .InstIllegal    (InstIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sparse memory image; unlisted words read as two c.nop-like halfwords.
  logic [31:0] memImg [logic [31:0]];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return memImg.exists(a) ? memImg[a] : 32'h0001_0001;
  endfunction

  // Memory responder: acts 1 time unit after each falling edge so its
  // outputs are stable around the next rising edge.
  int          rspLat = 0;
  bit          pendActive = 0;
  int          pendWait = 0;
  logic [31:0] pendAddr = '0;

  initial begin
    MemGnt    = 1'b0;
    MemRValid = 1'b0;
    MemRData  = '0;
    forever begin
      @(negedge clk);
      #1;
      MemRValid = 1'b0;
      if (pendActive) begin
        if (pendWait == 0) begin
          MemRValid  = 1'b1;
          MemRData   = memWord(pendAddr);
          pendActive = 0;
        end else begin
          pendWait--;
        end
      end
      MemGnt = 1'b0;
      if (MemReq === 1'b1 && !pendActive) begin
        MemGnt     = 1'b1;
        pendActive = 1;
        pendAddr   = MemAddr;
        pendWait   = rspLat;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (InstValid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 64'(InstValid), 64'h1);
  endtask

  // One handshake: Ready is high across exactly one rising edge.
  task automatic accept();
    InstReady = 1'b1;
    @(negedge clk);
    InstReady = 1'b0;
  endtask

  initial begin
    int n;
    memImg[32'h0000_0000] = 32'h4501_4581;
    memImg[32'h0000_0100] = 32'h4505_0000;
    memImg[32'h0000_0200] = 32'h0513_4581;
    memImg[32'h0000_0204] = 32'h0000_0050;

    rst_n      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    InstReady  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst MemReq", 64'(MemReq), 64'h0);
    check("rst InstValid", 64'(InstValid), 64'h0);
    check("rst InstPC", 64'(InstPC), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first MemReq", 64'(MemReq), 64'h1);
    check("first MemAddr", 64'(MemAddr), 64'h0);

    // Two compressed instructions from one beat
    waitValid("t1 i0");
    check("t1 i0 data", 64'(InstData), 64'h0000_4581);
    check("t1 i0 comp", 64'(InstCompressed), 64'h1);
    check("t1 i0 pc", 64'(InstPC), 64'h0);

    // Stall with the queue full: no fetch, head stable
    repeat (10) @(negedge clk);
    check("t3 stall MemReq", 64'(MemReq), 64'h0);
    check("t3 stall data", 64'(InstData), 64'h0000_4581);
    check("t3 stall comp", 64'(InstCompressed), 64'h1);
    check("t3 stall pc", 64'(InstPC), 64'h0);
    rspLat    = 3;
    InstReady = 1'b1;
    @(negedge clk);
    check("t1 i1 data", 64'(InstData), 64'h0000_4501);
    check("t1 i1 pc", 64'(InstPC), 64'h2);
    @(negedge clk);
    InstReady = 1'b0;
    check("t3 resume MemReq", 64'(MemReq), 64'h1);
    check("t3 resume MemAddr", 64'(MemAddr), 64'hC);
    check("t3 resume pc", 64'(InstPC), 64'h4);

    // Redirect to 0x102 while the beat at 0xC is outstanding
    @(negedge clk);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0102;
    @(negedge clk);
    Redirect = 1'b0;
    check("t4 InstValid", 64'(InstValid), 64'h0);
    check("t4 InstPC", 64'(InstPC), 64'h102);
    check("t4 MemReq held", 64'(MemReq), 64'h0);
    n = 0;
    while (MemReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4 MemReq", 64'(MemReq), 64'h1);
    check("t4 MemAddr", 64'(MemAddr), 64'h100);
    waitValid("t4 i0");
    check("t4 i0 data", 64'(InstData), 64'h0000_4505);
    check("t4 i0 comp", 64'(InstCompressed), 64'h1);
    check("t4 i0 pc", 64'(InstPC), 64'h102);

    // Redirect in the same cycle as a handshake and a read response
    n = 0;
    while (!(pendActive && pendWait == 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t5 pre InstValid", 64'(InstValid), 64'h1);
    InstReady  = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    rspLat     = 0;
    @(negedge clk);
    Redirect  = 1'b0;
    InstReady = 1'b0;
    check("t5 InstValid", 64'(InstValid), 64'h0);
    check("t5 InstPC", 64'(InstPC), 64'h200);
    check("t5 MemReq", 64'(MemReq), 64'h1);
    check("t5 MemAddr", 64'(MemAddr), 64'h200);

    // 32-bit instruction spanning two beats, then a 16'h0000 halfword
    waitValid("t2 i0");
    check("t2 i0 data", 64'(InstData), 64'h0000_4581);
    check("t2 i0 comp", 64'(InstCompressed), 64'h1);
    check("t2 i0 pc", 64'(InstPC), 64'h200);
    accept();
    waitValid("t2 i1");
    check("t2 i1 data", 64'(InstData), 64'h0050_0513);
    check("t2 i1 comp", 64'(InstCompressed), 64'h0);
    check("t2 i1 pc", 64'(InstPC), 64'h202);
    accept();
    waitValid("t6 i0");
    check("t6 illegal", 64'(InstIllegal), 64'(ILL_EXP));
    check("t6 comp", 64'(InstCompressed), 64'h1);
    check("t6 data", 64'(InstData), 64'h0);
    check("t6 pc", 64'(InstPC), 64'h206);
    accept();
    waitValid("t6 i1");
    check("t6 next pc", 64'(InstPC), 64'h208);

    // Reset with a beat in flight; its late response must be ignored
    rspLat    = 2;
    InstReady = 1'b1;
    n = 0;
    while (!pendActive && n < 40) begin
      @(negedge clk);
      n++;
    end
    InstReady = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst2 MemReq", 64'(MemReq), 64'h0);
    check("rst2 InstValid", 64'(InstValid), 64'h0);
    check("rst2 InstPC", 64'(InstPC), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitValid("rst2 i0");
    check("rst2 i0 data", 64'(InstData), 64'h0000_4581);
    check("rst2 i0 pc", 64'(InstPC), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
